// File: rtl/kbd_pkg.sv
// Shared constants and pop-FSM state type for the PS/2 scan-code sequencer.
package kbd_pkg;

    localparam logic [7:0] KBD_PFX_EXT = 8'hE0;
    localparam logic [7:0] KBD_PFX_BRK = 8'hF0;
    localparam logic [7:0] KBD_LSHIFT  = 8'h12;
    localparam logic [7:0] KBD_RSHIFT  = 8'h59;
    localparam logic [7:0] KBD_CTRL    = 8'h14;
    localparam logic [7:0] KBD_CAPS    = 8'h58;

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_GAP
    } pop_state_e;

endpackage

// File: rtl/kbd_scan_ctrl_if.sv
// Receiver FIFO handshake plus key-event/state bundle of kbd_scan_ctrl.
interface kbd_scan_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             ready;
    logic [7:0]       data;
    logic             overflow;
    logic             nextdata_n;
    logic             evt_valid;
    logic             evt_make;
    logic             evt_ext;
    logic [7:0]       evt_code;
    logic             key_down;
    logic [7:0]       last_code;
    logic [CNT_W-1:0] press_count;
    logic             shift;
    logic             ctrl;
    logic             caps;
    logic             ovf_sticky;

    modport master (
        output ready, data, overflow,
        input  nextdata_n, evt_valid, evt_make, evt_ext, evt_code,
        input  key_down, last_code, press_count,
        input  shift, ctrl, caps, ovf_sticky
    );

    modport slave (
        input  ready, data, overflow,
        output nextdata_n, evt_valid, evt_make, evt_ext, evt_code,
        output key_down, last_code, press_count,
        output shift, ctrl, caps, ovf_sticky
    );

endinterface

// File: rtl/kbd_mod_tracker.sv
// Shift/ctrl/caps-lock state, updated from the pre-register event strobe.
module kbd_mod_tracker
    import kbd_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       evt_i,
    input  logic       make_i,
    input  logic [7:0] code_i,
    output logic       shift_o,
    output logic       ctrl_o,
    output logic       caps_o
);

    logic lsh_q, lsh_d;
    logic rsh_q, rsh_d;
    logic ctrl_q, ctrl_d;
    logic caps_q, caps_d;
    logic shift_q;

    always_comb begin
        lsh_d  = lsh_q;
        rsh_d  = rsh_q;
        ctrl_d = ctrl_q;
        caps_d = caps_q;
        if (evt_i) begin
            unique case (1'b1)
                (code_i == KBD_LSHIFT): lsh_d  = make_i;
                (code_i == KBD_RSHIFT): rsh_d  = make_i;
                (code_i == KBD_CTRL):   ctrl_d = make_i;
                (code_i == KBD_CAPS):   caps_d = caps_q ^ make_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            lsh_q   <= 1'b0;
            rsh_q   <= 1'b0;
            ctrl_q  <= 1'b0;
            caps_q  <= 1'b0;
            shift_q <= 1'b0;
        end else begin
            lsh_q   <= lsh_d;
            rsh_q   <= rsh_d;
            ctrl_q  <= ctrl_d;
            caps_q  <= caps_d;
            shift_q <= lsh_d | rsh_d;
        end
    end

    assign shift_o = shift_q;
    assign ctrl_o  = ctrl_q;
    assign caps_o  = caps_q;

endmodule

// File: rtl/kbd_scan_ctrl.sv
// Single reader of the PS/2 receiver FIFO: pops bytes and parses make/break/E0 events.
// Define KBD_TYPEMATIC_FILTER_EN to swallow auto-repeat makes of the held key.
module kbd_scan_ctrl
    import kbd_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input logic            clk,
    input logic            clr,
    kbd_scan_ctrl_if.slave kbd
);

    pop_state_e       state_q;
    logic [7:0]       byte_q;
    logic             ext_q, brk_q;
    logic             nextdata_n_q;
    logic             evt_valid_q, evt_make_q, evt_ext_q;
    logic [7:0]       evt_code_q;
    logic             key_down_q;
    logic [7:0]       last_code_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic is_pfx, make_d, emit_d;

    always_comb begin
        is_pfx = (byte_q == KBD_PFX_EXT) || (byte_q == KBD_PFX_BRK);
        make_d = !brk_q;
        emit_d = (state_q == S_POP) && !is_pfx;
`ifdef KBD_TYPEMATIC_FILTER_EN
        // Auto-repeat of the held key is consumed without any side effect.
        if (make_d && (byte_q == last_code_q) && key_down_q)
            emit_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= S_IDLE;
            byte_q       <= 8'h00;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            nextdata_n_q <= 1'b1;
            evt_valid_q  <= 1'b0;
            evt_make_q   <= 1'b0;
            evt_ext_q    <= 1'b0;
            evt_code_q   <= 8'h00;
            key_down_q   <= 1'b0;
            last_code_q  <= 8'h00;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            evt_valid_q  <= 1'b0;
            nextdata_n_q <= 1'b1;
            ovf_q        <= ovf_q | kbd.overflow;
            unique case (state_q)
                S_IDLE: begin
                    if (kbd.ready) begin
                        byte_q       <= kbd.data;
                        nextdata_n_q <= 1'b0;
                        state_q      <= S_POP;
                    end
                end
                S_POP: begin
                    state_q <= S_GAP;
                    unique case (1'b1)
                        (byte_q == KBD_PFX_EXT): ext_q <= 1'b1;
                        (byte_q == KBD_PFX_BRK): brk_q <= 1'b1;
                        default: begin
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                        end
                    endcase
                    if (emit_d) begin
                        evt_valid_q <= 1'b1;
                        evt_make_q  <= make_d;
                        evt_ext_q   <= ext_q;
                        evt_code_q  <= byte_q;
                        if (make_d) begin
                            last_code_q <= byte_q;
                            key_down_q  <= 1'b1;
                            cnt_q       <= cnt_q + CNT_W'(1);
                        end else if (byte_q == last_code_q) begin
                            key_down_q  <= 1'b0;
                        end
                    end
                end
                S_GAP:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    kbd_mod_tracker u_mod (
        .clk    (clk),
        .clr    (clr),
        .evt_i  (emit_d),
        .make_i (make_d),
        .code_i (byte_q),
        .shift_o(kbd.shift),
        .ctrl_o (kbd.ctrl),
        .caps_o (kbd.caps)
    );

    assign kbd.nextdata_n  = nextdata_n_q;
    assign kbd.evt_valid   = evt_valid_q;
    assign kbd.evt_make    = evt_make_q;
    assign kbd.evt_ext     = evt_ext_q;
    assign kbd.evt_code    = evt_code_q;
    assign kbd.key_down    = key_down_q;
    assign kbd.last_code   = last_code_q;
    assign kbd.press_count = cnt_q;
    assign kbd.ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Bench for kbd_scan_ctrl: FIFO emulator, byte-level reference model, per-cycle compare.
module tb_kbd_scan_ctrl;

    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic clr = 1'b1;

    kbd_scan_ctrl_if #(.CNT_W(CNT_W)) bus ();

    kbd_scan_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .clr(clr),
        .kbd(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo[$];
    int         pop_t[$];

    bit         m_ext, m_brk, m_down, m_ls, m_rs, m_ctrl, m_caps;
    logic [7:0] m_last;
    int         m_cnt;
    bit         exp_evt, e_make, e_ext;
    logic [7:0] e_code;
    bit         exp_ovf;

    int         cyc = 0;
    int         last_pop = -100;
    int         n_pop = 0;
    bit         ready_prev = 0;
    int         n_make = 0, n_brk = 0;
    bit         ev_make, ev_ext;
    logic [7:0] ev_code;
    bit         ovf_req = 0, ovf_rand = 0;

    int n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_down = 0; m_ls = 0; m_rs = 0;
        m_ctrl = 0; m_caps = 0; m_last = 8'h00; m_cnt = 0;
        exp_evt = 0; exp_ovf = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit mk, filt;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            mk = !m_brk;
            filt = 0;
`ifdef KBD_TYPEMATIC_FILTER_EN
            filt = mk && (b == m_last) && m_down;
`endif
            if (!filt) begin
                exp_evt = 1; e_make = mk; e_ext = m_ext; e_code = b;
                if (mk) begin
                    m_last = b; m_down = 1; m_cnt++;
                end else if (b == m_last) m_down = 0;
                if (b == 8'h12) m_ls = mk;
                if (b == 8'h59) m_rs = mk;
                if (b == 8'h14) m_ctrl = mk;
                if (mk && b == 8'h58) m_caps = !m_caps;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    // Single compare/driver process: checks outputs, then advances the FIFO and model.
    always @(negedge clk) begin
        bit exp_pop;
        logic [7:0] b;
        cyc++;
        if (clr) begin
            model_reset();
            last_pop = -100;
        end else begin
            exp_pop = ready_prev && (cyc - last_pop >= 3);
            chk("nextdata_n", bus.nextdata_n, !exp_pop);
            chk("evt_valid", bus.evt_valid, exp_evt);
            if (exp_evt && bus.evt_valid) begin
                chk("evt_make", bus.evt_make, e_make);
                chk("evt_ext", bus.evt_ext, e_ext);
                chk("evt_code", bus.evt_code, e_code);
            end
            if (bus.evt_valid) begin
                ev_make = bus.evt_make; ev_ext = bus.evt_ext; ev_code = bus.evt_code;
                if (bus.evt_make) n_make++; else n_brk++;
            end
            chk("key_down", bus.key_down, m_down);
            chk("last_code", bus.last_code, m_last);
            chk("press_count", bus.press_count, m_cnt % (1 << CNT_W));
            chk("shift", bus.shift, m_ls | m_rs);
            chk("ctrl", bus.ctrl, m_ctrl);
            chk("caps", bus.caps, m_caps);
            chk("ovf_sticky", bus.ovf_sticky, exp_ovf);
            exp_evt = 0;
            if (bus.nextdata_n == 1'b0) begin
                if (fifo.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL pop_empty: pop strobe with empty fifo (cycle %0d)", cyc);
                end else begin
                    b = fifo.pop_front();
                    model_byte(b);
                    last_pop = cyc;
                    n_pop++;
                    pop_t.push_back(cyc);
                end
            end
        end
        bus.overflow = ovf_req || (ovf_rand && $urandom_range(0, 31) == 0);
        ovf_req = 0;
        if (bus.overflow) exp_ovf = 1;
        bus.ready = (fifo.size() != 0);
        bus.data = bus.ready ? fifo[0] : 8'h00;
        ready_prev = bus.ready;
    end

    task automatic do_reset();
        @(negedge clk); #1 clr = 1;
        repeat (2) @(negedge clk);
        #1 clr = 0;
    endtask

    task automatic drain(input int max_cyc);
        int k;
        for (k = 0; k < max_cyc; k++) begin
            @(negedge clk); #1;
            if (fifo.size() == 0 && cyc - last_pop >= 4) break;
        end
        if (k == max_cyc) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: %0d bytes left", fifo.size());
        end
    endtask

    function automatic logic [7:0] rnd_byte();
        int r;
        r = $urandom_range(0, 15);
        case (r)
            0, 1:       return 8'hE0;
            2, 3, 4:    return 8'hF0;
            5:          return 8'h12;
            6:          return 8'h59;
            7:          return 8'h14;
            8:          return 8'h58;
            9, 10:      return 8'h1C;
            11:         return 8'h75;
            12:         return 8'h23;
            default:    return 8'($urandom_range(1, 8'hDF));
        endcase
    endfunction

    initial begin
        int p0, m0, b0, k;
        logic [7:0] c;
        bus.ready = 0; bus.data = 8'h00; bus.overflow = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1 clr = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_nextdata_n", bus.nextdata_n, 1);
        chk("rst_press_count", bus.press_count, 0);
        chk("rst_key_down", bus.key_down, 0);

        // make then break
        m0 = n_make; b0 = n_brk;
        fifo.push_back(8'h1C);
        drain(100);
        chk("mb_make_evts", n_make - m0, 1);
        chk("mb_make_code", ev_code, 8'h1C);
        chk("mb_make_ext", ev_ext, 0);
        chk("mb_count", bus.press_count, 1);
        chk("mb_down", bus.key_down, 1);
        fifo.push_back(8'hF0); fifo.push_back(8'h1C);
        drain(100);
        chk("mb_brk_evts", n_brk - b0, 1);
        chk("mb_up", bus.key_down, 0);
        chk("mb_last", bus.last_code, 8'h1C);

        // handshake spacing and idle
        do_reset();
        pop_t.delete();
        p0 = n_pop;
        fifo.push_back(8'h23); fifo.push_back(8'h23); fifo.push_back(8'h23);
        drain(100);
        chk("hs_pops", n_pop - p0, 3);
        if (pop_t.size() >= 3) begin
            chk("hs_gap1", pop_t[1] - pop_t[0], 3);
            chk("hs_gap2", pop_t[2] - pop_t[1], 3);
        end
        p0 = n_pop;
        repeat (10) @(negedge clk);
        #1 chk("idle_no_pop", n_pop - p0, 0);

        // extended break
        m0 = n_make; b0 = n_brk;
        fifo.push_back(8'hE0); fifo.push_back(8'hF0); fifo.push_back(8'h75);
        drain(100);
        chk("xb_evts", (n_make - m0) + (n_brk - b0), 1);
        chk("xb_make", ev_make, 0);
        chk("xb_ext", ev_ext, 1);
        chk("xb_code", ev_code, 8'h75);

        // typematic repeat
        do_reset();
        m0 = n_make;
        fifo.push_back(8'h1C); fifo.push_back(8'h1C); fifo.push_back(8'h1C);
        fifo.push_back(8'hF0); fifo.push_back(8'h1C);
        drain(100);
`ifdef KBD_TYPEMATIC_FILTER_EN
        chk("tm_count", bus.press_count, 1);
        chk("tm_makes", n_make - m0, 1);
`else
        chk("tm_count", bus.press_count, 3);
        chk("tm_makes", n_make - m0, 3);
`endif
        chk("tm_down", bus.key_down, 0);

        // modifiers
        do_reset();
        fifo.push_back(8'h12); fifo.push_back(8'h59);
        fifo.push_back(8'hF0); fifo.push_back(8'h12);
        drain(100);
        chk("mod_shift", bus.shift, 1);
        fifo.push_back(8'h58);
        drain(100);
        chk("mod_caps_on", bus.caps, 1);
        fifo.push_back(8'hF0); fifo.push_back(8'h58);
        fifo.push_back(8'h58); fifo.push_back(8'hF0); fifo.push_back(8'h58);
        drain(100);
        chk("mod_caps_off", bus.caps, 0);

        // counter wrap over 256 distinct make/break pairs
        do_reset();
        for (int i = 0; i < 256; i++) begin
            c = 8'(i % 128 + 1);
            if (i >= 128) fifo.push_back(8'hE0);
            fifo.push_back(c);
            if (i >= 128) fifo.push_back(8'hE0);
            fifo.push_back(8'hF0);
            fifo.push_back(c);
        end
        drain(5000);
        chk("wrap_model", m_cnt, 256);
        chk("wrap_count", bus.press_count, 0);

        // randomized traffic
        do_reset();
        ovf_rand = 1;
        for (int i = 0; i < 400; i++) begin
            fifo.push_back(rnd_byte());
            k = $urandom_range(0, 5);
            repeat (k) @(negedge clk);
            #1;
        end
        ovf_rand = 0;
        drain(3000);

        // overflow sticky, then clear mid-POP
        do_reset();
        ovf_req = 1;
        repeat (3) @(negedge clk);
        #1 chk("ovf_set", bus.ovf_sticky, 1);
        repeat (20) @(negedge clk);
        #1 chk("ovf_hold", bus.ovf_sticky, 1);
        fifo.push_back(8'h12); fifo.push_back(8'h1C);
        drain(100);
        fifo.push_back(8'h58);
        for (k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (!bus.nextdata_n) break;
        end
        chk("clr_found_pop", bus.nextdata_n, 0);
        clr = 1;
        #1;
        chk("clr_nextdata_n", bus.nextdata_n, 1);
        chk("clr_key_down", bus.key_down, 0);
        chk("clr_count", bus.press_count, 0);
        chk("clr_shift", bus.shift, 0);
        chk("clr_caps", bus.caps, 0);
        chk("clr_ovf", bus.ovf_sticky, 0);
        chk("clr_evt", bus.evt_valid, 0);
        @(negedge clk); #1 clr = 0;
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
